// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and requester IDs for the data-SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic {ARB_FREE, ARB_LOCK} arb_st_t;

    typedef logic arb_id_t;

    localparam arb_id_t ID_CORE = 1'b0;
    localparam arb_id_t ID_EXT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_if.sv
// ============================================================================
// Module   : dmem_arb_if
// Brief    : Requester 0/1 ports and SRAM bus of the data-SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic            m0_req;
    logic [AW-1:0]   m0_a;
    logic [DW/8-1:0] m0_we;
    logic [DW-1:0]   m0_wd;
    logic [DW/8-1:0] m0_re;
    logic            m0_gnt;
    logic            m0_rvld;
    logic [DW-1:0]   m0_rd;

    logic            m1_req;
    logic [AW-1:0]   m1_a;
    logic [DW/8-1:0] m1_we;
    logic [DW-1:0]   m1_wd;
    logic [DW/8-1:0] m1_re;
    logic            m1_lock;
    logic            m1_gnt;
    logic            m1_rvld;
    logic [DW-1:0]   m1_rd;

    logic [AW-1:0]   dat_a;
    logic [DW/8-1:0] dat_we;
    logic [DW-1:0]   dat_wd;
    logic [DW/8-1:0] dat_re;
    logic [DW-1:0]   dat_rd;

    // Requesters plus SRAM side
    modport master (
        output m0_req, m0_a, m0_we, m0_wd, m0_re,
        output m1_req, m1_a, m1_we, m1_wd, m1_re, m1_lock,
        input  m0_gnt, m0_rvld, m0_rd,
        input  m1_gnt, m1_rvld, m1_rd,
        input  dat_a, dat_we, dat_wd, dat_re,
        output dat_rd
    );

    modport slave (
        input  m0_req, m0_a, m0_we, m0_wd, m0_re,
        input  m1_req, m1_a, m1_we, m1_wd, m1_re, m1_lock,
        output m0_gnt, m0_rvld, m0_rd,
        output m1_gnt, m1_rvld, m1_rd,
        output dat_a, dat_we, dat_wd, dat_re,
        input  dat_rd
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_sel.sv
// ============================================================================
// Module   : dmem_arb_sel
// Brief    : Combinational winner select; tie rule set by DMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_sel
    import dmem_arb_pkg::*;
(
    input  logic    m0_req_i,
    input  logic    m1_req_i,
    input  arb_st_t st_i,
`ifdef DMEM_ARB_RR_EN
    input  arb_id_t last_i,
`else
    input  logic    wait_sat_i,
`endif
    output logic    m0_gnt_o,
    output logic    m1_gnt_o
);

    logic w_ext_wins_tie;

`ifdef DMEM_ARB_RR_EN
    assign w_ext_wins_tie = (last_i == ID_CORE);
`else
    assign w_ext_wins_tie = wait_sat_i;
`endif

    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (st_i == ARB_LOCK) begin
            m1_gnt_o = m1_req_i;
        end else if (m0_req_i && m1_req_i) begin
            m1_gnt_o = w_ext_wins_tie;
            m0_gnt_o = !w_ext_wins_tie;
        end else begin
            m0_gnt_o = m0_req_i;
            m1_gnt_o = m1_req_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arb.sv
// ============================================================================
// Module   : dmem_arb
// Brief    : Two-requester data-SRAM arbiter with bounded lock and read return.
//            Define DMEM_ARB_RR_EN for round-robin instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MAXWAIT  = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    dmem_arb_if.slave  bus
);

    localparam int BW = DW / 8;
    localparam int LW = $clog2(LOCK_MAX + 1);

    arb_st_t       st_q, st_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          rd_pend_q, rd_pend_d;
    arb_id_t       rd_owner_q, rd_owner_d;

    logic          w_sel0, w_sel1, w_gnt0, w_gnt1;
    logic          w_rvld0, w_rvld1;
    logic [AW-1:0] w_a;
    logic [BW-1:0] w_we, w_re;
    logic [DW-1:0] w_wd;

`ifdef DMEM_ARB_RR_EN
    // Holds the requester favoured on the next tie, so reset 0 lets requester 0 win first
    arb_id_t nxt_q, nxt_d;

    always_comb begin
        nxt_d = nxt_q;
        if (w_gnt0)      nxt_d = ID_EXT;
        else if (w_gnt1) nxt_d = ID_CORE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) nxt_q <= ID_CORE;
        else     nxt_q <= nxt_d;
    end

    dmem_arb_sel u_sel (
        .m0_req_i (bus.m0_req),
        .m1_req_i (bus.m1_req),
        .st_i     (st_q),
        .last_i   (~nxt_q),
        .m0_gnt_o (w_sel0),
        .m1_gnt_o (w_sel1)
    );
`else
    localparam int WW = $clog2(MAXWAIT + 1);

    logic [WW-1:0] wait_q, wait_d;
    logic          w_wait_sat;

    assign w_wait_sat = (wait_q == WW'(MAXWAIT));

    always_comb begin
        wait_d = wait_q;
        if (w_gnt1)                         wait_d = '0;
        else if (bus.m1_req && !w_wait_sat) wait_d = wait_q + WW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end

    dmem_arb_sel u_sel (
        .m0_req_i   (bus.m0_req),
        .m1_req_i   (bus.m1_req),
        .st_i       (st_q),
        .wait_sat_i (w_wait_sat),
        .m0_gnt_o   (w_sel0),
        .m1_gnt_o   (w_sel1)
    );
`endif

    assign w_gnt0 = w_sel0 && !rst;
    assign w_gnt1 = w_sel1 && !rst;

    // Lock length counts every granted cycle of the episode, including the entry cycle
    always_comb begin
        st_d   = st_q;
        lock_d = lock_q;
        case (st_q)
            ARB_FREE: begin
                if (w_gnt1 && bus.m1_lock && (LOCK_MAX > 1)) begin
                    st_d   = ARB_LOCK;
                    lock_d = LW'(1);
                end
            end
            ARB_LOCK: begin
                lock_d = lock_q + LW'(1);
                if (!bus.m1_lock || !bus.m1_req || (lock_q == LW'(LOCK_MAX - 1))) begin
                    st_d   = ARB_FREE;
                    lock_d = '0;
                end
            end
            default: begin
                st_d   = ARB_FREE;
                lock_d = '0;
            end
        endcase
    end

    // A request carrying both enables is a write, so its read enables are dropped
    always_comb begin
        w_a  = '0;
        w_we = '0;
        w_wd = '0;
        w_re = '0;
        if (w_gnt0) begin
            w_a  = bus.m0_a;
            w_we = bus.m0_we;
            w_wd = bus.m0_wd;
            w_re = (|bus.m0_we) ? '0 : bus.m0_re;
        end else if (w_gnt1) begin
            w_a  = bus.m1_a;
            w_we = bus.m1_we;
            w_wd = bus.m1_wd;
            w_re = (|bus.m1_we) ? '0 : bus.m1_re;
        end
    end

    assign rd_pend_d  = |w_re;
    assign rd_owner_d = w_gnt1 ? ID_EXT : ID_CORE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ARB_FREE;
            lock_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= ID_CORE;
        end else begin
            st_q       <= st_d;
            lock_q     <= lock_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign w_rvld0 = rd_pend_q && (rd_owner_q == ID_CORE);
    assign w_rvld1 = rd_pend_q && (rd_owner_q == ID_EXT);

    assign bus.m0_gnt  = w_gnt0;
    assign bus.m1_gnt  = w_gnt1;
    assign bus.m0_rvld = w_rvld0;
    assign bus.m1_rvld = w_rvld1;
    assign bus.m0_rd   = w_rvld0 ? bus.dat_rd : '0;
    assign bus.m1_rd   = w_rvld1 ? bus.dat_rd : '0;
    assign bus.dat_a   = w_a;
    assign bus.dat_we  = w_we;
    assign bus.dat_wd  = w_wd;
    assign bus.dat_re  = w_re;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arb.sv
// ============================================================================
// Module   : tb_dmem_arb
// Brief    : Randomized scoreboard bench for dmem_arb with an access-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arb;
    import dmem_arb_pkg::*;

    localparam int AW       = 16;
    localparam int DW       = 32;
    localparam int MAXWAIT  = 8;
    localparam int LOCK_MAX = 16;

    typedef struct packed {
        logic        v;
        logic [15:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [3:0]  re;
    } txn_t;

    typedef struct packed {
        logic        id;
        logic [31:0] d;
        logic [63:0] due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arb_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arb #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT), .LOCK_MAX(LOCK_MAX)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    // SRAM: 16 words, low address bits only, 1-cycle read
    logic [31:0] sram [16];
    logic        sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
            sram_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.dat_we[b]) sram[bus.dat_a[3:0]][8*b +: 8] <= bus.dat_wd[8*b +: 8];
            if (|bus.dat_re) bus.dat_rd <= sram[bus.dat_a[3:0]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [16];
    exp_t        exp_q [$];
    bit          locked;
    int          lock_run;
    int          refused;
    bit          fav;
    txn_t        t0, t1;
    int          kind0, kind1, lock_mode;

    function automatic txn_t gen(int kind);
        txn_t t;
        t.v  = 1'b0;
        t.a  = 16'($urandom);
        t.wd = $urandom;
        t.we = '0;
        t.re = '0;
        case (kind)
            1: if ($urandom_range(0, 99) < 60) begin
                t.v = 1'b1;
                case ($urandom_range(0, 3))
                    0: t.re = 4'($urandom_range(1, 15));
                    1: t.we = 4'($urandom_range(1, 15));
                    2: begin
                        t.we = 4'($urandom_range(1, 15));
                        t.re = 4'($urandom_range(1, 15));
                    end
                    default: ;
                endcase
            end
            2: begin
                t.v  = 1'b1;
                t.we = 4'($urandom_range(1, 15));
            end
            default: ;
        endcase
        return t;
    endfunction

    function automatic txn_t rd_txn(logic [15:0] a);
        txn_t t;
        t.v  = 1'b1;
        t.a  = a;
        t.we = '0;
        t.wd = $urandom;
        t.re = 4'hF;
        return t;
    endfunction

    task automatic drive_idle();
        bus.m0_req = 1'b0; bus.m0_a = '0; bus.m0_we = '0; bus.m0_wd = '0; bus.m0_re = '0;
        bus.m1_req = 1'b0; bus.m1_a = '0; bus.m1_we = '0; bus.m1_wd = '0; bus.m1_re = '0;
        bus.m1_lock = 1'b0;
    endtask

    function automatic bit tie_to_ext();
`ifdef DMEM_ARB_RR_EN
        return fav;
`else
        return refused >= MAXWAIT;
`endif
    endfunction

    task automatic issue(input logic id, input txn_t t);
        logic [3:0] ere;
        ere = (t.we != 0) ? 4'h0 : t.re;
        check("dat_a",  bus.dat_a,  t.a);
        check("dat_we", bus.dat_we, t.we);
        check("dat_wd", bus.dat_wd, t.wd);
        check("dat_re", bus.dat_re, ere);
        for (int b = 0; b < 4; b++)
            if (t.we[b]) ref_mem[t.a[3:0]][8*b +: 8] = t.wd[8*b +: 8];
        if (ere != 0) exp_q.push_back('{id: id, d: ref_mem[t.a[3:0]], due: 64'($time) + 64'd9});
    endtask

    task automatic step(output logic g0, output logic g1);
        logic lk;
        @(negedge clk);
        if (!t0.v) t0 = gen(kind0);
        if (!t1.v) t1 = gen(kind1);
        case (lock_mode)
            1:       lk = 1'b1;
            2:       lk = 1'b0;
            default: lk = ($urandom_range(0, 3) == 0);
        endcase
        bus.m0_req = t0.v; bus.m0_a = t0.a; bus.m0_we = t0.we; bus.m0_wd = t0.wd; bus.m0_re = t0.re;
        bus.m1_req = t1.v; bus.m1_a = t1.a; bus.m1_we = t1.we; bus.m1_wd = t1.wd; bus.m1_re = t1.re;
        bus.m1_lock = lk;
        #1;
        if (locked)             g1 = t1.v;
        else if (t0.v && t1.v)  g1 = tie_to_ext();
        else                    g1 = t1.v;
        g0 = !locked && t0.v && !g1;
        check("m0_gnt", bus.m0_gnt, g0);
        check("m1_gnt", bus.m1_gnt, g1);
        if (g0)      issue(1'b0, t0);
        else if (g1) issue(1'b1, t1);
        else begin
            check("idle_dat", {bus.dat_a, bus.dat_we, bus.dat_wd, bus.dat_re}, '0);
        end
        if (g1)        refused = 0;
        else if (t1.v) refused++;
        if (g0)      fav = 1'b1;
        else if (g1) fav = 1'b0;
        if (g1 && lk) begin
            lock_run = (locked ? lock_run : 0) + 1;
            locked   = (lock_run < LOCK_MAX);
        end else begin
            locked   = 1'b0;
            lock_run = 0;
        end
        if (g0) t0.v = 1'b0;
        if (g1) t1.v = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        locked = 1'b0; lock_run = 0; refused = 0; fav = 1'b0;
        exp_q.delete();
        t0.v = 1'b0; t1.v = 1'b0;
        #1;
        check("rst_gnt",  {bus.m0_gnt, bus.m1_gnt}, 2'b00);
        check("rst_rvld", {bus.m0_rvld, bus.m1_rvld}, 2'b00);
        check("rst_rd",   {bus.m0_rd, bus.m1_rd}, '0);
        check("rst_dat",  {bus.dat_a, bus.dat_we, bus.dat_wd, bus.dat_re}, '0);
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops the expected read return whenever one is due
    always @(negedge clk) begin
        if (!rst) begin
            check("rvld_overlap", bus.m0_rvld & bus.m1_rvld, 1'b0);
            if (!bus.m0_rvld) check("m0_rd_zero", bus.m0_rd, '0);
            if (!bus.m1_rvld) check("m1_rd_zero", bus.m1_rd, '0);
            while (exp_q.size() > 0 && exp_q[0].due < 64'($time)) begin
                check("rvld_stale", exp_q[0].due, 64'($time));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == 64'($time)) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rvld_owner", {bus.m1_rvld, bus.m0_rvld}, e.id ? 2'b10 : 2'b01);
                check("rd_data", e.id ? bus.m1_rd : bus.m0_rd, e.d);
            end else begin
                check("rvld_spurious", {bus.m1_rvld, bus.m0_rvld}, 2'b00);
            end
        end
    end

    initial begin
        logic g0, g1;
        int   m1_cyc [$];
        int   run, first_m0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        t0 = '0; t1 = '0;
        kind0 = 0; kind1 = 0; lock_mode = 2;
        drive_idle();
        do_reset();

        // Single read
        t0 = rd_txn(16'h0010);
        step(g0, g1);
        check("single_rd_gnt", g0, 1'b1);
        step(g0, g1);
        step(g0, g1);

        // Contention with writes from both sides
        do_reset();
        kind0 = 2; kind1 = 2; lock_mode = 2;
        for (int c = 1; c <= 20; c++) begin
            step(g0, g1);
            if (g1) m1_cyc.push_back(c);
        end
`ifdef DMEM_ARB_RR_EN
        check("rr_m1_count", m1_cyc.size(), 10);
        check("rr_m1_first", m1_cyc[0], 2);
`else
        check("starve_m1_count", m1_cyc.size(), 2);
        check("starve_m1_first", m1_cyc[0], 9);
        check("starve_m1_second", m1_cyc[1], 18);
`endif

        // Bounded lock
        do_reset();
        kind0 = 0; kind1 = 2; lock_mode = 1;
        run = 30; first_m0 = 0;
        for (int c = 1; c <= 30; c++) begin
            step(g0, g1);
            if (c == 1) kind0 = 2;
            if (!g1 && run == 30) run = c - 1;
            if (g0 && first_m0 == 0) first_m0 = c;
        end
        check("lock_run", run, LOCK_MAX);
        check("lock_m0_after", first_m0, LOCK_MAX + 1);

        // Alternating reads
        do_reset();
        kind0 = 0; kind1 = 0; lock_mode = 2;
        t0 = rd_txn(16'h0004);
        step(g0, g1);
        check("alt_m0_gnt", g0, 1'b1);
        t1 = rd_txn(16'h0008);
        step(g0, g1);
        check("alt_m1_gnt", g1, 1'b1);
        step(g0, g1);
        step(g0, g1);

        // Reset in the cycle after an m1 read grant
        t1 = rd_txn(16'h0003);
        step(g0, g1);
        check("rst_rd_gnt", g1, 1'b1);
        do_reset();
        kind0 = 2; kind1 = 2;
        step(g0, g1);
        check("post_rst_free", {g0, bus.m0_gnt}, 2'b11);

        // Randomized traffic
        do_reset();
        kind0 = 1; kind1 = 1; lock_mode = 0;
        for (int c = 0; c < 3000; c++) step(g0, g1);
        kind0 = 0; kind1 = 0; lock_mode = 2;
        for (int c = 0; c < 40; c++) step(g0, g1);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
